// File: rtl/pipe_pkg.sv
// Shared types and defaults for pipeline boundary registers.
package pipe_pkg;

  localparam int          PIPE_INSTR_W  = 16;
  localparam int          PIPE_PC_W     = 16;
  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;

  typedef logic [1:0] occ_t;

  typedef struct packed {
    logic [PIPE_INSTR_W-1:0] instr;
    logic [PIPE_PC_W-1:0]    pc2;
    logic [PIPE_PC_W-1:0]    pc_cur;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry with its valid bit; pc_cur can be held while the rest loads.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter type entry_t = pipe_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   drop,
  input  logic   flush,
  input  logic   pc_hold,
  input  entry_t d,
  output logic   valid,
  output entry_t q
);

  // Flush only invalidates; the payload is kept so downstream sees stable fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      q.instr <= d.instr;
      q.pc2   <= d.pc2;
      if (!pc_hold) begin
        q.pc_cur <= d.pc_cur;
      end
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, optional skid entry,
// flush-to-bubble and halt-gated current-PC capture.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 INSTR_W   = PIPE_INSTR_W,
  parameter int                 PC_W      = PIPE_PC_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
  parameter bit                 SKID_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc2_in,
  input  logic [PC_W-1:0]    pc_cur_in,
  input  logic               halt,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc2_out,
  output logic [PC_W-1:0]    pc_cur_out,
  output logic               halted,
  output occ_t               occupancy
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc2;
    logic [PC_W-1:0]    pc_cur;
  } entry_t;

  logic   head_valid, skid_valid;
  entry_t head_q, skid_q, in_entry, head_d;
  logic   accept, issue;
  logic   head_load, head_drop, head_pc_hold;
  logic   skid_load, skid_drop;

  assign in_entry = {instr_in, pc2_in, pc_cur_in};

  // With a skid entry, ready depends only on state; without one it must look at out_ready.
  assign in_ready = SKID_EN ? ~skid_valid : (out_ready | ~head_valid);

  always_comb begin
    accept       = in_valid & in_ready;
    issue        = head_valid & out_ready;
    head_load    = 1'b0;
    head_drop    = 1'b0;
    head_d       = in_entry;
    head_pc_hold = halt;
    skid_load    = 1'b0;
    skid_drop    = 1'b0;
    if (issue && skid_valid) begin
      // Skid entry already captured its pc_cur, so it moves up unmodified.
      head_load    = 1'b1;
      head_d       = skid_q;
      head_pc_hold = 1'b0;
      skid_drop    = 1'b1;
    end else if (accept && (!head_valid || issue)) begin
      head_load = 1'b1;
    end else if (accept) begin
      skid_load = SKID_EN;
    end else if (issue) begin
      head_drop = 1'b1;
    end
  end

  // Stage boundary: head entry drives the outputs
  pipe_entry_reg #(.entry_t(entry_t)) u_head (
    .clk     (clk),
    .rst     (rst),
    .load    (head_load),
    .drop    (head_drop),
    .flush   (flush),
    .pc_hold (head_pc_hold),
    .d       (head_d),
    .valid   (head_valid),
    .q       (head_q)
  );

  if (SKID_EN) begin : g_skid
    pipe_entry_reg #(.entry_t(entry_t)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load    (skid_load),
      .drop    (skid_drop),
      .flush   (flush),
      .pc_hold (halt),
      .d       (in_entry),
      .valid   (skid_valid),
      .q       (skid_q)
    );
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_q     = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      halted <= 1'b0;
    end else if (halt) begin
      halted <= 1'b1;
    end
  end

  assign out_valid  = head_valid;
  assign instr_out  = head_valid ? head_q.instr : NOP_INSTR;
  assign pc2_out    = head_q.pc2;
  assign pc_cur_out = head_q.pc_cur;
  assign occupancy  = {1'b0, head_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed table, skid-less corner cases, and a
// queue-based reference model driven by random handshakes.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, halt, flush;
  logic        in_valid, out_ready, in_valid0, out_ready0;
  logic [15:0] instr_in, pc2_in, pc_cur_in;

  logic        in_ready, out_valid, halted;
  logic [15:0] instr_out, pc2_out, pc_cur_out;
  logic [1:0]  occupancy;
  logic        in_ready0, out_valid0, halted0;
  logic [15:0] instr_out0, pc2_out0, pc_cur_out0;
  logic [1:0]  occupancy0;

  pipe_stage_reg #(.SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc2_in(pc2_in), .pc_cur_in(pc_cur_in),
    .halt(halt), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .instr_out(instr_out), .pc2_out(pc2_out), .pc_cur_out(pc_cur_out),
    .halted(halted), .occupancy(occupancy)
  );

  pipe_stage_reg #(.SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .instr_in(instr_in), .pc2_in(pc2_in), .pc_cur_in(pc_cur_in),
    .halt(halt), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready0),
    .instr_out(instr_out0), .pc2_out(pc2_out0), .pc_cur_out(pc_cur_out0),
    .halted(halted0), .occupancy(occupancy0)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [15:0] instr;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic [15:0] io;
    logic [1:0]  occ;
    logic        ir;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [15:0] ins, logic ordy, logic fl,
                              logic ov, logic [15:0] io, logic [1:0] occ, logic ir);
    vec_t v;
    v.iv = iv; v.instr = ins; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.io = io; v.occ = occ; v.ir = ir;
    return v;
  endfunction

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
    logic [15:0] pc;
  } ent_t;

  // Reference model: an ordered queue per DUT, plus the last entry shown at the head.
  ent_t q1[$], q0[$];
  ent_t disp1, disp0, hd;
  logic exp_ir1, exp_ir0;
  vec_t tbl[$];

  task automatic check_side(input string tag, input int n, input ent_t head, input ent_t dp,
                            input logic ir_exp, input logic ov, input logic [15:0] io,
                            input logic [15:0] p2, input logic [15:0] pc,
                            input logic [1:0] occ, input logic ir, input logic hl);
    chk({tag, " out_valid"}, 32'(ov), 32'(n > 0));
    chk({tag, " instr_out"}, 32'(io), 32'((n > 0) ? head.instr : NOP));
    chk({tag, " pc2_out"}, 32'(p2), 32'(dp.pc2));
    chk({tag, " pc_cur_out"}, 32'(pc), 32'(dp.pc));
    chk({tag, " occupancy"}, 32'(occ), 32'(n));
    chk({tag, " in_ready"}, 32'(ir), 32'(ir_exp));
    chk({tag, " halted"}, 32'(hl), 32'd0);
  endtask

  initial begin
    rst = 1'b0; halt = 1'b0; flush = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0; in_valid0 = 1'b1; out_ready0 = 1'b0;
    instr_in = 16'h7777; pc2_in = 16'h1111; pc_cur_in = 16'h2222;

    // Reset held two cycles with in_valid high.
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst instr_out", 32'(instr_out), 32'(NOP));
    chk("rst occupancy", 32'(occupancy), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst pc2_out", 32'(pc2_out), 32'd0);
    chk("rst pc_cur_out", 32'(pc_cur_out), 32'd0);
    chk("rst0 out_valid", 32'(out_valid0), 32'd0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0;
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'd1);

    // Directed table: streaming, stall/skid, flush (skid build).
    tbl.push_back(mk(1'b1, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h1234, 2'd1, 1'b1));
    tbl.push_back(mk(1'b1, 16'h5678, 1'b1, 1'b0, 1'b1, 16'h5678, 2'd1, 1'b1));
    tbl.push_back(mk(1'b1, 16'h9ABC, 1'b1, 1'b0, 1'b1, 16'h9ABC, 2'd1, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, NOP,      2'd0, 1'b1));
    tbl.push_back(mk(1'b1, 16'hA001, 1'b0, 1'b0, 1'b1, 16'hA001, 2'd1, 1'b1));
    tbl.push_back(mk(1'b1, 16'hA002, 1'b0, 1'b0, 1'b1, 16'hA001, 2'd2, 1'b0));
    tbl.push_back(mk(1'b1, 16'hA003, 1'b0, 1'b0, 1'b1, 16'hA001, 2'd2, 1'b0));
    tbl.push_back(mk(1'b1, 16'hA003, 1'b1, 1'b0, 1'b1, 16'hA002, 2'd1, 1'b1));
    tbl.push_back(mk(1'b1, 16'hA003, 1'b1, 1'b0, 1'b1, 16'hA003, 2'd1, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, NOP,      2'd0, 1'b1));
    tbl.push_back(mk(1'b1, 16'hB001, 1'b0, 1'b0, 1'b1, 16'hB001, 2'd1, 1'b1));
    tbl.push_back(mk(1'b1, 16'hB002, 1'b0, 1'b0, 1'b1, 16'hB001, 2'd2, 1'b0));
    tbl.push_back(mk(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, NOP,      2'd0, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, NOP,      2'd0, 1'b1));
    tbl.push_back(mk(1'b1, 16'hC001, 1'b1, 1'b0, 1'b1, 16'hC001, 2'd1, 1'b1));
    tbl.push_back(mk(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0, NOP,      2'd0, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, NOP,      2'd0, 1'b1));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      in_valid = tbl[i].iv; instr_in = tbl[i].instr; out_ready = tbl[i].ordy;
      flush = tbl[i].fl; pc2_in = tbl[i].instr ^ 16'h00FF; pc_cur_in = tbl[i].instr;
      @(posedge clk);
      #1;
      chk($sformatf("tbl[%0d] out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl[%0d] instr_out", i), 32'(instr_out), 32'(tbl[i].io));
      chk($sformatf("tbl[%0d] occupancy", i), 32'(occupancy), 32'(tbl[i].occ));
      chk($sformatf("tbl[%0d] in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
    end

    // Skid-less build: single entry under stall, then one entry per cycle.
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid0 = 1'b1; out_ready0 = 1'b0; instr_in = 16'hD001;
    @(posedge clk); #1;
    chk("ns stall1 instr", 32'(instr_out0), 32'hD001);
    chk("ns stall1 occ", 32'(occupancy0), 32'd1);
    chk("ns stall1 in_ready", 32'(in_ready0), 32'd0);
    @(negedge clk);
    instr_in = 16'hD002;
    @(posedge clk); #1;
    chk("ns stall2 instr", 32'(instr_out0), 32'hD001);
    chk("ns stall2 occ", 32'(occupancy0), 32'd1);
    @(negedge clk);
    out_ready0 = 1'b1;
    #1;
    chk("ns release in_ready", 32'(in_ready0), 32'd1);
    @(posedge clk); #1;
    chk("ns stream1 instr", 32'(instr_out0), 32'hD002);
    @(negedge clk);
    instr_in = 16'hD003;
    @(posedge clk); #1;
    chk("ns stream2 instr", 32'(instr_out0), 32'hD003);
    chk("ns stream2 occ", 32'(occupancy0), 32'd1);
    @(negedge clk);
    in_valid0 = 1'b0;
    @(posedge clk); #1;
    chk("ns drain out_valid", 32'(out_valid0), 32'd0);

    // Random handshakes against the queue model, both builds side by side.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    q1.delete(); q0.delete(); disp1 = '0; disp0 = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid   = 1'($urandom_range(0, 1));
      in_valid0  = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 3) != 0);
      out_ready0 = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      instr_in   = 16'($urandom);
      pc2_in     = 16'($urandom);
      pc_cur_in  = 16'($urandom);
      #1;
      exp_ir1 = (q1.size() < 2);
      exp_ir0 = (q0.size() == 0) || out_ready0;
      hd = (q1.size() > 0) ? q1[0] : disp1;
      check_side("skid", q1.size(), hd, disp1, exp_ir1, out_valid, instr_out,
                 pc2_out, pc_cur_out, occupancy, in_ready, halted);
      hd = (q0.size() > 0) ? q0[0] : disp0;
      check_side("noskid", q0.size(), hd, disp0, exp_ir0, out_valid0, instr_out0,
                 pc2_out0, pc_cur_out0, occupancy0, in_ready0, halted0);
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (q1.size() > 0 && out_ready) void'(q1.pop_front());
        if (in_valid && exp_ir1) q1.push_back({instr_in, pc2_in, pc_cur_in});
        if (q0.size() > 0 && out_ready0) void'(q0.pop_front());
        if (in_valid0 && exp_ir0) q0.push_back({instr_in, pc2_in, pc_cur_in});
      end
      if (q1.size() > 0) disp1 = q1[0];
      if (q0.size() > 0) disp0 = q0[0];
    end

    // Halt: pc_cur held across a capture, halted sticky through flush.
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    instr_in = 16'h1111; pc2_in = 16'h0042; pc_cur_in = 16'h0040; halt = 1'b0;
    @(posedge clk); #1;
    chk("halt first pc_cur", 32'(pc_cur_out), 32'h0040);
    chk("halt first halted", 32'(halted), 32'd0);
    @(negedge clk);
    instr_in = 16'h2222; pc2_in = 16'h0044; pc_cur_in = 16'h0042; halt = 1'b1;
    @(posedge clk); #1;
    chk("halt second instr", 32'(instr_out), 32'h2222);
    chk("halt second pc2", 32'(pc2_out), 32'h0044);
    chk("halt second pc_cur", 32'(pc_cur_out), 32'h0040);
    chk("halt second halted", 32'(halted), 32'd1);
    @(negedge clk);
    halt = 1'b0; in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    chk("halt flush out_valid", 32'(out_valid), 32'd0);
    chk("halt flush halted", 32'(halted), 32'd1);
    chk("halt flush pc_cur held", 32'(pc_cur_out), 32'h0040);
    @(negedge clk);
    flush = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    chk("halt reset halted", 32'(halted), 32'd0);
    chk("halt reset pc_cur", 32'(pc_cur_out), 32'd0);
    chk("halt reset instr", 32'(instr_out), 32'(NOP));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
